// File: rtl/planificador_pkg.sv
// Shared types and constants for the action scheduler between the buttons and
// the pet-state controller.
package planificador_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        COOLDOWN = 1'b1
    } estado_t;

    localparam int unsigned ACC_DORMIR = 0;
    localparam int unsigned ACC_COMER  = 1;
    localparam int unsigned ACC_JUGAR  = 2;
    localparam int unsigned N_ACC      = 3;

    localparam int unsigned COOLDOWN_S_DEF = 2;
    localparam int unsigned HOLD_S_DEF     = 5;

    // Pending requests that remain legal for the current pet state.
    function automatic logic [N_ACC-1:0] filtrar(
        input logic [N_ACC-1:0] pend,
        input logic             muerto,
        input logic             dormido,
        input logic             enfermo
    );
        logic [N_ACC-1:0] k;
        k = pend;
        if (muerto) begin
            k = '0;
        end else if (dormido) begin
            k[ACC_COMER] = 1'b0;
            k[ACC_JUGAR] = 1'b0;
        end else if (enfermo) begin
            k[ACC_DORMIR] = 1'b0;
        end
        return k;
    endfunction

endpackage

// File: rtl/detector_pulsacion_larga.sv
// One-shot pulse once btn has been held for HOLD_S ticks; re-arms on release.
module detector_pulsacion_larga
    import planificador_pkg::*;
#(
    parameter int unsigned HOLD_S = HOLD_S_DEF,
    parameter int unsigned CNT_W  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic pulse
);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] hold_next;
    logic             pulse_q, pulse_d;

    assign hold_next = hold_cnt_q + CNT_W'(1);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        pulse_d    = 1'b0;
        if (!btn) begin
            hold_cnt_d = '0;
        end else if (tick && (hold_cnt_q != CNT_W'(HOLD_S))) begin
            // Counter saturates at HOLD_S, so the pulse cannot repeat while held.
            hold_cnt_d = hold_next;
            pulse_d    = (hold_next == CNT_W'(HOLD_S));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/planificador_acciones.sv
// Turns button presses into filtered, cooldown-spaced action pulses plus a
// long-press reset request. `define PLANIF_RR_EN for comer/jugar round-robin.
module planificador_acciones
    import planificador_pkg::*;
#(
    parameter int unsigned COOLDOWN_S = COOLDOWN_S_DEF,
    parameter int unsigned HOLD_S     = HOLD_S_DEF,
    parameter int unsigned CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1s,
    input  logic btn_comer,
    input  logic btn_jugar,
    input  logic btn_dormir,
    input  logic btn_reset,
    input  logic muerto,
    input  logic dormido,
    input  logic enfermo,
    output logic pulse_comer,
    output logic pulse_jugar,
    output logic pulse_dormir,
    output logic pulse_despertar,
    output logic reset_req,
    output logic busy
);

    logic [N_ACC-1:0] btn_now, rise, keep, grant;
    logic [N_ACC-1:0] btn_hist_q;
    logic [N_ACC-1:0] pend_q, pend_d;
    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_comer_q, pulse_comer_d;
    logic             pulse_jugar_q, pulse_jugar_d;
    logic             pulse_dormir_q, pulse_dormir_d;
    logic             pulse_despertar_q, pulse_despertar_d;
    logic             reset_req_w;
    logic             tie_jugar;

    assign btn_now[ACC_DORMIR] = btn_dormir;
    assign btn_now[ACC_COMER]  = btn_comer;
    assign btn_now[ACC_JUGAR]  = btn_jugar;

    detector_pulsacion_larga #(
        .HOLD_S (HOLD_S),
        .CNT_W  (CNT_W)
    ) u_pulsacion_larga (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_1s),
        .btn   (btn_reset),
        .pulse (reset_req_w)
    );

`ifdef PLANIF_RR_EN
    // rr_q set: comer was served last, so jugar wins the next tie.
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (grant[ACC_COMER]) begin
            rr_d = 1'b1;
        end else if (grant[ACC_JUGAR]) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign tie_jugar = rr_q;
`else
    assign tie_jugar = 1'b0;
`endif

    always_comb begin
        rise    = btn_now & ~btn_hist_q;
        keep    = filtrar(pend_q, muerto, dormido, enfermo);
        grant   = '0;
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if ((|keep) && !reset_req_w) begin
                    if (keep[ACC_DORMIR]) begin
                        grant[ACC_DORMIR] = 1'b1;
                    end else if (keep[ACC_COMER] && (!keep[ACC_JUGAR] || !tie_jugar)) begin
                        grant[ACC_COMER] = 1'b1;
                    end else begin
                        grant[ACC_JUGAR] = 1'b1;
                    end
                    state_d = COOLDOWN;
                    cnt_d   = CNT_W'(COOLDOWN_S);
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else if (tick_1s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset_req_w) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // A fresh rise re-arms a source even in the cycle it is being granted.
        pend_d = reset_req_w ? '0 : ((keep & ~grant) | rise);

        pulse_dormir_d    = grant[ACC_DORMIR] & ~dormido;
        pulse_despertar_d = grant[ACC_DORMIR] & dormido;
        pulse_comer_d     = grant[ACC_COMER];
        pulse_jugar_d     = grant[ACC_JUGAR];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            pend_q            <= '0;
            btn_hist_q        <= btn_now;
            pulse_comer_q     <= 1'b0;
            pulse_jugar_q     <= 1'b0;
            pulse_dormir_q    <= 1'b0;
            pulse_despertar_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            pend_q            <= pend_d;
            btn_hist_q        <= btn_now;
            pulse_comer_q     <= pulse_comer_d;
            pulse_jugar_q     <= pulse_jugar_d;
            pulse_dormir_q    <= pulse_dormir_d;
            pulse_despertar_q <= pulse_despertar_d;
        end
    end

    assign pulse_comer     = pulse_comer_q;
    assign pulse_jugar     = pulse_jugar_q;
    assign pulse_dormir    = pulse_dormir_q;
    assign pulse_despertar = pulse_despertar_q;
    assign reset_req       = reset_req_w;
    assign busy            = (state_q == COOLDOWN);

endmodule
